// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the memory-manager data port: one transaction at a time,
// fixed read latency, one-cycle ack. Define ARB_FIXED_PRIO_EN for CPU-first priority.
module mem_port_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic [DW-1:0] rdata0,
    output logic          ack0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic [DW-1:0] rdata1,
    output logic          ack1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          grant
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          grant_q, grant_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          busy_q, busy_d;
    logic          win;
`ifndef ARB_FIXED_PRIO_EN
    logic          last_q, last_d;
`endif

    // Winner index, only meaningful when at least one request is present.
    always_comb begin
`ifdef ARB_FIXED_PRIO_EN
        win = ~req0;
`else
        if (req0 && req1) begin
            win = ~last_q;
        end else begin
            win = ~req0;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
        last_d      = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    state_d     = S_ISSUE;
                    grant_d     = win;
                    mem_en_d    = 1'b1;
                    mem_we_d    = win ? we1 : we0;
                    mem_addr_d  = win ? addr1 : addr0;
                    mem_wdata_d = win ? wdata1 : wdata0;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = 3'(RD_LAT);
            end
            S_WAIT: begin
                // Final wait cycle: mem_rdata is valid now, so capture it and raise ack.
                if (cnt_q == 3'd1) begin
                    state_d = S_DONE;
                    if (grant_q) begin
                        rdata1_d = mem_rdata;
                        ack1_d   = 1'b1;
                    end else begin
                        rdata0_d = mem_rdata;
                        ack0_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
`ifndef ARB_FIXED_PRIO_EN
                last_d  = grant_q;
`endif
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            grant_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            busy_q      <= busy_d;
`ifndef ARB_FIXED_PRIO_EN
            last_q      <= last_d;
`endif
        end
    end

    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign grant     = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected transactions,
// a negedge monitor checks issue strobes and acks against them.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [DW-1:0] rdata0, rdata1;
    logic          ack0, ack1;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy, grant;

    mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .rdata0(rdata0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .rdata1(rdata1), .ack1(ack1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .grant(grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          chk_rd;
        int          req_cyc;
        int          gap;
    } txn_t;

    txn_t exp_q[$];
    txn_t fly_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   ack_cnt = 0;
    int   issue_cyc = 0;
    int   last_ack_cyc = 0;
    bit   en_prev = 1'b0;

    logic [31:0] mem_model [bit [31:0]];
    bit          m_active = 1'b0;
    int          m_since = 0;
    logic [31:0] m_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: valid data only on the final wait cycle, changing garbage otherwise.
    always @(negedge clk) begin
        if (rst) begin
            m_active = 1'b0;
            m_since  = 0;
        end else if (mem_en) begin
            m_active = 1'b1;
            m_since  = 0;
            m_addr   = mem_addr;
            if (mem_we) mem_model[mem_addr] = mem_wdata;
        end else if (m_active) begin
            m_since++;
        end
        if (m_active && m_since == LAT) begin
            mem_rdata = mem_model.exists(m_addr) ? mem_model[m_addr] : 32'h0;
            m_active  = 1'b0;
        end else begin
            mem_rdata = 32'h5A5A_0000 | 32'(m_since);
        end
    end

    // Monitor: pops expectations whenever the DUT issues or acknowledges.
    always @(negedge clk) begin
        txn_t t;
        if (!rst) begin
            check("ack_exclusive", ack0 & ack1, 0);
            if (en_prev) check("mem_en_pulse", mem_en, 0);
            if (busy && !mem_en && fly_q.size() > 0) begin
                check("addr_hold", mem_addr, fly_q[0].addr);
                check("we_hold", mem_we, fly_q[0].we);
            end
            if (mem_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", exp_q.size(), 1);
                end else begin
                    t = exp_q.pop_front();
                    check("issue_grant", grant, t.port);
                    check("issue_we", mem_we, t.we);
                    check("issue_addr", mem_addr, t.addr);
                    check("issue_busy", busy, 1);
                    if (t.we) check("issue_wdata", mem_wdata, t.wdata);
                    if (t.req_cyc >= 0) check("issue_latency", cyc - t.req_cyc, 1);
                    issue_cyc = cyc;
                    fly_q.push_back(t);
                end
            end
            if (ack0 || ack1) begin
                if (fly_q.size() == 0) begin
                    check("unexpected_ack", fly_q.size(), 1);
                end else begin
                    t = fly_q.pop_front();
                    check("ack_port", ack1, t.port);
                    check("ack_grant", grant, t.port);
                    check("ack_latency", cyc - issue_cyc, LAT + 1);
                    if (t.chk_rd) check("ack_rdata", t.port ? rdata1 : rdata0, t.rdata);
                    if (t.gap > 0) check("ack_spacing", cyc - last_ack_cyc, t.gap);
                end
                last_ack_cyc = cyc;
                ack_cnt++;
            end
        end
        en_prev = mem_en;
    end

    task automatic expect_txn(input bit port, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input bit chk_rd, input int req_cyc, input int gap);
        txn_t t;
        t.port = port; t.we = we; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        t.chk_rd = chk_rd; t.req_cyc = req_cyc; t.gap = gap;
        exp_q.push_back(t);
    endtask

    task automatic drive(input bit port, input bit req, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            req1 = req; we1 = we; addr1 = addr; wdata1 = wdata;
        end else begin
            req0 = req; we0 = we; addr0 = addr; wdata0 = wdata;
        end
    endtask

    // Returns at the rising edge that ends the DONE cycle of the target ack.
    task automatic wait_acks(input int target, input int budget);
        int k;
        k = 0;
        while (ack_cnt < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (ack_cnt < target) check("ack_timeout", ack_cnt, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack0"}, ack0, 0);
        check({tag, "_ack1"}, ack1, 0);
        check({tag, "_rdata0"}, rdata0, 0);
        check({tag, "_rdata1"}, rdata1, 0);
        check({tag, "_mem_en"}, mem_en, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_grant"}, grant, 0);
    endtask

    function automatic bit tie_port(input int i);
`ifdef ARB_FIXED_PRIO_EN
        return (i < 4) ? 1'b0 : 1'b1;
`else
        return (i < 4) ? i[0] : 1'b1;
`endif
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        rst = 1'b1;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        mem_rdata = '0;
        mem_model[32'h10]  = 32'hDEAD_BEEF;
        mem_model[32'h20]  = 32'h1234_5678;
        mem_model[32'h100] = 32'hAAAA_0001;
        mem_model[32'h200] = 32'hBBBB_0002;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single read on port 0.
        @(posedge clk); #1;
        drive(0, 1, 0, 32'h10, 32'h0);
        expect_txn(0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1, cyc, 0);
        wait_acks(1, 30);
        #1 req0 = 0;
        check("busy_after_ack", busy, 0);

        // Write on port 1, then port 1 reads it back.
        drive(1, 1, 1, 32'h400, 32'hA5);
        expect_txn(1, 1, 32'h400, 32'hA5, 32'h0, 0, cyc, 0);
        wait_acks(2, 30);
        #1 req1 = 0;
        check("rdata0_hold", rdata0, 32'hDEAD_BEEF);
        drive(1, 1, 0, 32'h400, 32'h0);
        expect_txn(1, 0, 32'h400, 32'h0, 32'hA5, 1, cyc, 0);
        wait_acks(3, 30);
        #1 req1 = 0;

        // Both ports request continuously; port 1 keeps requesting after port 0 drops.
        drive(0, 1, 0, 32'h100, 32'h0);
        drive(1, 1, 0, 32'h200, 32'h0);
        for (int i = 0; i < 5; i++) begin
            expect_txn(tie_port(i), 0, tie_port(i) ? 32'h200 : 32'h100, 32'h0,
                       tie_port(i) ? 32'hBBBB_0002 : 32'hAAAA_0001, 1,
                       (i == 0) ? cyc : -1, (i == 0) ? 0 : LAT + 3);
        end
        wait_acks(7, 100);
        #1 req0 = 0;
        wait_acks(8, 30);
        #1 req1 = 0;

        // Request dropped right after being seen still completes.
        drive(0, 1, 0, 32'h20, 32'h0);
        expect_txn(0, 0, 32'h20, 32'h0, 32'h1234_5678, 1, cyc, 0);
        @(posedge clk); #1 req0 = 0;
        wait_acks(9, 30);

        // Reset asserted during WAIT discards the transaction.
        #1;
        drive(0, 1, 0, 32'h10, 32'h0);
        expect_txn(0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1, cyc, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        req0 = 0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        fly_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // After reset: tie goes to port 0, then port 1, no stale ack.
        base = ack_cnt;
        @(posedge clk); #1;
        drive(0, 1, 0, 32'h10, 32'h0);
        drive(1, 1, 0, 32'h200, 32'h0);
        expect_txn(0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1, cyc, 0);
        expect_txn(1, 0, 32'h200, 32'h0, 32'hBBBB_0002, 1, -1, LAT + 3);
        wait_acks(base + 1, 30);
        #1 req0 = 0;
        wait_acks(base + 2, 30);
        #1 req1 = 0;

        repeat (4) @(posedge clk);
        check("scoreboard_drained", exp_q.size() + fly_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
